// File: rtl/score_digit_ctrl.sv
// Score counter with saturation at 255 and an iterative 8-step double-dabble to three BCD digits.
// Optional best-score register and display select are enabled by defining SCORE_HIGH_SCORE_EN.
//
// state | meaning
// IDLE  | digits stable; loads the shift register when a conversion is pending
// SHIFT | one adjust-and-shift double-dabble step per clock, 8 steps
// DONE  | latch digits, pulse digits_upd, return to IDLE
module score_digit_ctrl #(
    parameter int CONV_STEPS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_reset,
    input  logic       point,
    input  logic       game_over,
    input  logic       show_best,
    output logic [7:0] score,
    output logic [7:0] best_score,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       busy,
    output logic       digits_upd
);

    localparam logic [2:0] LAST_STEP = 3'(CONV_STEPS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    logic [7:0]  score_nxt;
    logic [7:0]  src_cur;
    logic [7:0]  src_nxt;
    logic        pending;
    logic        pending_set;
    logic [19:0] shreg;
    logic [19:0] shreg_adj;
    logic [2:0]  step;

    always_comb begin
        score_nxt = score;
        if (game_reset)
            score_nxt = 8'd0;
        else if (point && score != 8'hFF)
            score_nxt = score + 8'd1;
    end

`ifdef SCORE_HIGH_SCORE_EN
    logic [7:0] best_nxt;
    logic       sel_q;

    // Compare against the post-increment score so a point on the final cycle counts.
    always_comb begin
        best_nxt = best_score;
        if (game_over && score_nxt > best_score)
            best_nxt = score_nxt;
    end

    assign src_cur     = sel_q ? best_score : score;
    assign src_nxt     = show_best ? best_nxt : score_nxt;
    assign pending_set = (src_nxt != src_cur) || (show_best != sel_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_score <= 8'd0;
            sel_q      <= 1'b0;
        end else begin
            best_score <= best_nxt;
            sel_q      <= show_best;
        end
    end
`else
    logic unused_inputs;

    assign unused_inputs = show_best ^ game_over;
    assign best_score    = 8'd0;
    assign src_cur       = score;
    assign src_nxt       = score_nxt;
    assign pending_set   = (src_nxt != src_cur);
`endif

    always_comb begin
        shreg_adj = shreg;
        for (int i = 0; i < 3; i++) begin
            if (shreg[8 + 4*i +: 4] >= 4'd5)
                shreg_adj[8 + 4*i +: 4] = shreg[8 + 4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            score      <= 8'd0;
            pending    <= 1'b0;
            shreg      <= 20'd0;
            step       <= 3'd0;
            hundreds   <= 4'd0;
            tens       <= 4'd0;
            ones       <= 4'd0;
            busy       <= 1'b0;
            digits_upd <= 1'b0;
        end else begin
            score      <= score_nxt;
            digits_upd <= 1'b0;
            // A change on the load edge itself must survive the clear.
            pending    <= pending_set || (pending && state != IDLE);
            case (state)
                IDLE: begin
                    if (pending) begin
                        shreg <= {12'd0, src_cur};
                        step  <= 3'd0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg <= {shreg_adj[18:0], 1'b0};
                    step  <= step + 3'd1;
                    if (step == LAST_STEP)
                        state <= DONE;
                end
                DONE: begin
                    hundreds   <= shreg[19:16];
                    tens       <= shreg[15:12];
                    ones       <= shreg[11:8];
                    digits_upd <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
